status_reporter: RTL and testbench

Encodes menu and pump state changes into the single-byte command codes the mode controller decodes, then serializes them as 8N1 UART frames back to the Bluetooth/PC link. It sits beside the mode controller and watches its `btn_LR_out`, `btn_UD_out` and pump pulse outputs, so the phone app and PC track local button activity. Reports are coalesced per class, so bursts of button presses never overflow and the latest value is always reported.

---
 rtl/aroma_cmd_pkg.sv | 65 ++++++
 rtl/uart_tx_byte.sv | 128 ++++++++++++
 rtl/status_reporter.sv | 114 +++++++++++
 tb/tb_status_reporter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aroma_cmd_pkg.sv
// Shared command definitions for the aroma diffuser link.
// Holds the single-byte command codes decoded by the mode controller, the
// scent/timer menu indices, the default UART bit period, the encoders that
// turn a menu index into a command, and the serializer state encoding.
package aroma_cmd_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;  // 1 MHz / 9600 baud

  localparam logic [1:0] SCENT_COTTON = 2'd0;
  localparam logic [1:0] SCENT_WOODY  = 2'd1;
  localparam logic [1:0] SCENT_CITRUS = 2'd2;

  localparam logic [1:0] TIMER_30     = 2'd0;
  localparam logic [1:0] TIMER_60     = 2'd1;
  localparam logic [1:0] TIMER_120    = 2'd2;

  localparam logic [7:0] CMD_CITRUS    = 8'h01;
  localparam logic [7:0] CMD_COTTON    = 8'h02;
  localparam logic [7:0] CMD_WOODY     = 8'h03;
  localparam logic [7:0] CMD_PUMP_ON   = 8'h04;
  localparam logic [7:0] CMD_PUMP_OFF  = 8'h05;
  localparam logic [7:0] CMD_TIMER_30  = 8'h1E;
  localparam logic [7:0] CMD_TIMER_60  = 8'h3C;
  localparam logic [7:0] CMD_TIMER_120 = 8'h78;

  // Encoded command; vld is low for the invalid menu index 3.
  typedef struct packed {
    logic       vld;
    logic [7:0] code;
  } cmd_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic cmd_t scent_cmd(input logic [1:0] idx);
    cmd_t c;
    c.vld  = 1'b1;
    c.code = 8'h00;
    case (idx)
      SCENT_COTTON: c.code = CMD_COTTON;
      SCENT_WOODY:  c.code = CMD_WOODY;
      SCENT_CITRUS: c.code = CMD_CITRUS;
      default:      c.vld  = 1'b0;
    endcase
    return c;
  endfunction

  function automatic cmd_t timer_cmd(input logic [1:0] idx);
    cmd_t c;
    c.vld  = 1'b1;
    c.code = 8'h00;
    case (idx)
      TIMER_30:  c.code = CMD_TIMER_30;
      TIMER_60:  c.code = CMD_TIMER_60;
      TIMER_120: c.code = CMD_TIMER_120;
      default:   c.vld  = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start, data  load request and byte, accepted only in IDLE
//   tx           serial line, idles high
//   busy         high from the first START cycle through the last STOP cycle
//   done         one-cycle pulse on the last STOP cycle
// Every state lasts CLKS_PER_BIT cycles; data goes out LSB first.
// All outputs are registered, so they are computed one cycle ahead.
module uart_tx_byte
  import aroma_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PEN  = BW'(CLKS_PER_BIT - 2);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_end;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = TX_START;
          shreg_d = data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shift out the bit just sent; the next one is at shreg_q[1].
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        // done is registered, so raise it while entering the last cycle.
        done_d = (baud_q == BAUD_PEN);
        if (baud_end) begin
          baud_d  = '0;
          state_d = TX_IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/status_reporter.sv
// Reports menu and pump state changes to the Bluetooth/PC link as 8N1
// UART command bytes.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   scent_sel, timer_sel       current menu indices (3 = invalid, never sent)
//   pump_on_evt, pump_off_evt  one-cycle pump pulses (off wins if both)
//   report_all                 one-cycle request to re-send scent and timer
//   tx, tx_busy, tx_done       UART line and serializer status
// One pending flag per class coalesces bursts; the byte is encoded from the
// live input when it is loaded, so the latest value is always the one sent.
module status_reporter
  import aroma_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] scent_sel,
  input  logic [1:0] timer_sel,
  input  logic       pump_on_evt,
  input  logic       pump_off_evt,
  input  logic       report_all,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  logic [1:0] scent_prev_q, scent_prev_d;
  logic [1:0] timer_prev_q, timer_prev_d;
  logic       pend_scent_q, pend_scent_d;
  logic       pend_timer_q, pend_timer_d;
  logic       pend_pump_q, pend_pump_d;
  logic       pump_val_q, pump_val_d;

  logic       set_scent, set_timer, set_pump;
  logic       clr_scent, clr_timer, clr_pump;
  logic       start;
  logic [7:0] start_data;
  cmd_t       scent_c, timer_c;

  always_comb begin
    set_scent = (scent_sel != scent_prev_q) | report_all;
    set_timer = (timer_sel != timer_prev_q) | report_all;
    set_pump  = pump_on_evt | pump_off_evt;
    scent_c   = scent_cmd(scent_sel);
    timer_c   = timer_cmd(timer_sel);

    clr_scent  = 1'b0;
    clr_timer  = 1'b0;
    clr_pump   = 1'b0;
    start      = 1'b0;
    start_data = 8'h00;
    // Arbiter: pump > scent > timer. An invalid index clears its flag
    // without starting a frame.
    if (!tx_busy) begin
      if (pend_pump_q) begin
        clr_pump   = 1'b1;
        start      = 1'b1;
        start_data = pump_val_q ? CMD_PUMP_ON : CMD_PUMP_OFF;
      end else if (pend_scent_q) begin
        clr_scent  = 1'b1;
        start      = scent_c.vld;
        start_data = scent_c.code;
      end else if (pend_timer_q) begin
        clr_timer  = 1'b1;
        start      = timer_c.vld;
        start_data = timer_c.code;
      end
    end

    // A new event in the load cycle re-arms the flag it just cleared.
    pend_scent_d = (pend_scent_q & ~clr_scent) | set_scent;
    pend_timer_d = (pend_timer_q & ~clr_timer) | set_timer;
    pend_pump_d  = (pend_pump_q & ~clr_pump) | set_pump;

    pump_val_d = pump_val_q;
    if (pump_off_evt)     pump_val_d = 1'b0;
    else if (pump_on_evt) pump_val_d = 1'b1;

    scent_prev_d = scent_sel;
    timer_prev_d = timer_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scent_prev_q <= 2'd0;
      timer_prev_q <= 2'd0;
      pend_scent_q <= 1'b0;
      pend_timer_q <= 1'b0;
      pend_pump_q  <= 1'b0;
      pump_val_q   <= 1'b0;
    end else begin
      scent_prev_q <= scent_prev_d;
      timer_prev_q <= timer_prev_d;
      pend_scent_q <= pend_scent_d;
      pend_timer_q <= pend_timer_d;
      pend_pump_q  <= pend_pump_d;
      pump_val_q   <= pump_val_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (start_data),
    .tx   (tx),
    .busy (tx_busy),
    .done (tx_done)
  );

endmodule

// File: tb/tb_status_reporter.sv
module tb_status_reporter;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] scent_sel, timer_sel;
  logic       pump_on_evt, pump_off_evt, report_all;
  logic       tx, tx_busy, tx_done;

  int total = 0;
  int bad = 0;

  logic [39:0] ln, bs, dn;
  int lat, act;

  status_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .scent_sel(scent_sel), .timer_sel(timer_sel),
    .pump_on_evt(pump_on_evt), .pump_off_evt(pump_off_evt),
    .report_all(report_all), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Expected line level for each of the 40 cycles of an 8N1 frame.
  function automatic logic [39:0] frame_line(input logic [7:0] d);
    logic [9:0]  b;
    logic [39:0] r;
    b = {1'b1, d, 1'b0};
    for (int c = 0; c < 40; c++) r[c] = b[c / CPB];
    return r;
  endfunction

  // Waits (bounded) for a start bit and records 40 cycles of line/busy/done.
  // lat counts negedges up to and including the first low one; -1 = none.
  task automatic grab(output logic [39:0] l, output logic [39:0] b,
                      output logic [39:0] d, output int lt);
    l = '1; b = '0; d = '0; lt = 0;
    do begin
      @(negedge clk);
      lt++;
    end while (tx !== 1'b0 && lt < 300);
    if (tx !== 1'b0) begin
      lt = -1;
    end else begin
      for (int c = 0; c < 40; c++) begin
        if (c > 0) @(negedge clk);
        l[c] = tx;
        b[c] = tx_busy;
        d[c] = tx_done;
      end
    end
  endtask

  // Counts cycles in which the link shows any activity.
  task automatic quiet(input int n, output int a);
    a = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) a++;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; scent_sel = 2'd0; timer_sel = 2'd0;
    pump_on_evt = 1'b0; pump_off_evt = 1'b0; report_all = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    reset = 1'b0;
    quiet(20, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL reset_quiet got=%0d exp=0", act); end
  endtask

  task automatic test_scent_change;
    step; scent_sel = 2'd2;
    step;
    grab(ln, bs, dn, lat);
    total += 4;
    if (lat !== 2) begin bad++; $display("FAIL scent_lat got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h01)) begin bad++; $display("FAIL scent_frame got=%h exp=%h", ln, frame_line(8'h01)); end
    if (bs !== '1) begin bad++; $display("FAIL scent_busy got=%h exp=ffffffffff", bs); end
    if (dn !== 40'h80_0000_0000) begin bad++; $display("FAIL scent_done got=%h exp=8000000000", dn); end
    @(negedge clk);
    total += 2;
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL scent_busy_drop got=%b exp=0", tx_busy); end
    if (tx !== 1'b1) begin bad++; $display("FAIL scent_idle_tx got=%b exp=1", tx); end
    quiet(30, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL scent_quiet got=%0d exp=0", act); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp [3];
    exp[0] = 8'h04; exp[1] = 8'h03; exp[2] = 8'h3C;
    step; timer_sel = 2'd1; scent_sel = 2'd1; pump_on_evt = 1'b1;
    step; pump_on_evt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      grab(ln, bs, dn, lat);
      total += 2;
      if (lat !== 2) begin bad++; $display("FAIL simul_lat%0d got=%0d exp=2", k, lat); end
      if (ln !== frame_line(exp[k])) begin bad++; $display("FAIL simul_frame%0d got=%h exp=%h", k, ln, frame_line(exp[k])); end
    end
    quiet(30, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL simul_quiet got=%0d exp=0", act); end
  endtask

  task automatic test_coalesce;
    step; scent_sel = 2'd0; pump_on_evt = 1'b1;
    step; pump_on_evt = 1'b0;
    fork
      grab(ln, bs, dn, lat);
      begin
        repeat (8) @(posedge clk);
        #1 scent_sel = 2'd1;
        repeat (8) @(posedge clk);
        #1 scent_sel = 2'd2;
      end
    join
    total++;
    if (ln !== frame_line(8'h04)) begin bad++; $display("FAIL coal_pump got=%h exp=%h", ln, frame_line(8'h04)); end
    grab(ln, bs, dn, lat);
    total += 2;
    if (lat !== 2) begin bad++; $display("FAIL coal_lat got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h01)) begin bad++; $display("FAIL coal_frame got=%h exp=%h", ln, frame_line(8'h01)); end
    quiet(60, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL coal_quiet got=%0d exp=0", act); end
  endtask

  task automatic test_pump_conflict;
    step; scent_sel = 2'd0;
    fork
      grab(ln, bs, dn, lat);
      begin
        repeat (6) @(posedge clk);
        #1 pump_on_evt = 1'b1;
        @(posedge clk); #1 pump_on_evt = 1'b0;
        repeat (2) @(posedge clk);
        #1 pump_off_evt = 1'b1;
        @(posedge clk); #1 pump_off_evt = 1'b0;
      end
    join
    total++;
    if (ln !== frame_line(8'h02)) begin bad++; $display("FAIL pump_scent got=%h exp=%h", ln, frame_line(8'h02)); end
    grab(ln, bs, dn, lat);
    total += 2;
    if (lat !== 2) begin bad++; $display("FAIL pump_busy_lat got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h05)) begin bad++; $display("FAIL pump_busy_frame got=%h exp=%h", ln, frame_line(8'h05)); end
    quiet(60, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL pump_busy_quiet got=%0d exp=0", act); end
    step; pump_on_evt = 1'b1; pump_off_evt = 1'b1;
    step; pump_on_evt = 1'b0; pump_off_evt = 1'b0;
    grab(ln, bs, dn, lat);
    total += 2;
    if (lat !== 2) begin bad++; $display("FAIL pump_same_lat got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h05)) begin bad++; $display("FAIL pump_same_frame got=%h exp=%h", ln, frame_line(8'h05)); end
    quiet(60, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL pump_same_quiet got=%0d exp=0", act); end
  endtask

  task automatic test_invalid_report_all;
    step; timer_sel = 2'd3;
    quiet(60, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL inv_timer_quiet got=%0d exp=0", act); end
    // report_all with an invalid timer: scent only.
    step; report_all = 1'b1;
    step; report_all = 1'b0;
    grab(ln, bs, dn, lat);
    total += 2;
    if (lat !== 2) begin bad++; $display("FAIL inv_ra_lat got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h02)) begin bad++; $display("FAIL inv_ra_frame got=%h exp=%h", ln, frame_line(8'h02)); end
    quiet(60, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL inv_ra_quiet got=%0d exp=0", act); end
    step; timer_sel = 2'd2;
    step;
    grab(ln, bs, dn, lat);
    total++;
    if (ln !== frame_line(8'h78)) begin bad++; $display("FAIL timer120_frame got=%h exp=%h", ln, frame_line(8'h78)); end
    step; scent_sel = 2'd1;
    step;
    grab(ln, bs, dn, lat);
    total++;
    if (ln !== frame_line(8'h03)) begin bad++; $display("FAIL woody_frame got=%h exp=%h", ln, frame_line(8'h03)); end
    quiet(10, act);
    step; report_all = 1'b1;
    step; report_all = 1'b0;
    grab(ln, bs, dn, lat);
    total += 2;
    if (lat !== 2) begin bad++; $display("FAIL ra_lat0 got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h03)) begin bad++; $display("FAIL ra_frame0 got=%h exp=%h", ln, frame_line(8'h03)); end
    grab(ln, bs, dn, lat);
    total += 2;
    if (lat !== 2) begin bad++; $display("FAIL ra_lat1 got=%0d exp=2", lat); end
    if (ln !== frame_line(8'h78)) begin bad++; $display("FAIL ra_frame1 got=%h exp=%h", ln, frame_line(8'h78)); end
    quiet(60, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL ra_quiet got=%0d exp=0", act); end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    step; report_all = 1'b1;
    step; report_all = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 300);
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL rst_mid_start got=%b exp=0", tx); end
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", tx_busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", tx_done); end
    scent_sel = 2'd0; timer_sel = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet(80, act);
    total++;
    if (act !== 0) begin bad++; $display("FAIL rst_mid_quiet got=%0d exp=0", act); end
  endtask

  initial begin
    test_reset;
    test_scent_change;
    test_simultaneous;
    test_coalesce;
    test_pump_conflict;
    test_invalid_report_all;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
